// File: rtl/scpu_irq_ctrl.sv
// Sound-CPU interrupt controller: 4-deep command FIFO fed by the main CPU, a periodic
// timer, and an IDLE/REQ/ACK interrupt handshake that supplies a vector on acknowledge.

module scpu_irq_ctrl #(
    parameter int         TMR_PERIOD = 200000,
    parameter logic [7:0] CMD_VEC    = 8'hFF,
    parameter logic [7:0] TMR_VEC    = 8'hF7
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       main_cmd_wr,
    input  logic [7:0] main_cmd_data,
    output logic       main_cmd_full,
    input  logic [7:0] scpu_ab,
    input  logic       scpu_io,
    input  logic       scpu_rd,
    input  logic       scpu_wr,
    input  logic       scpu_m1,
    input  logic [7:0] scpu_dout,
    output logic [7:0] scpu_io_din,
    output logic       scpu_io_sel,
    output logic       scpu_int
);

    localparam logic [23:0] TMR_LAST = 24'(TMR_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t      state_q, state_d;
    logic        pend_tmr_q, pend_tmr_d;
    logic [7:0]  fifo_q [4];
    logic [7:0]  fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        tmr_en_q, tmr_en_d;
    logic        cmd_en_q, cmd_en_d;
    logic        tmr_flag_q, tmr_flag_d;
    logic [23:0] tmr_cnt_q, tmr_cnt_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd0_q, wr1_q, wr2_q, ack_q;

    logic        rd0_cond, rd1_cond, wr1_cond, wr2_cond, ack_cond;
    logic        rd0_rise, wr1_rise, wr2_rise, ack_rise;
    logic        full, empty, push, pop, cmd_pend, tmr_wrap, tmr_clr_ack, ack_window;
    logic [7:0]  head, status;

    assign rd0_cond = scpu_io & scpu_rd & ~scpu_m1 & (scpu_ab == 8'd0);
    assign rd1_cond = scpu_io & scpu_rd & ~scpu_m1 & (scpu_ab == 8'd1);
    assign wr1_cond = scpu_io & scpu_wr & ~scpu_m1 & (scpu_ab == 8'd1);
    assign wr2_cond = scpu_io & scpu_wr & ~scpu_m1 & (scpu_ab == 8'd2);
    assign ack_cond = scpu_io & scpu_m1;

    // Bus strobes last several cycles; each event fires only on its first cycle.
    assign rd0_rise = rd0_cond & ~rd0_q;
    assign wr1_rise = wr1_cond & ~wr1_q;
    assign wr2_rise = wr2_cond & ~wr2_q;
    assign ack_rise = ack_cond & ~ack_q;

    assign full     = (count_q == 3'd4);
    assign empty    = (count_q == 3'd0);
    assign head     = empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign pop      = rd0_rise & ~empty;
    assign push     = main_cmd_wr & (~full | pop);
    assign cmd_pend = cmd_en_q & ~empty;
    assign tmr_wrap = tmr_en_q & (tmr_cnt_q == TMR_LAST);
    assign status   = {2'b00, full, tmr_flag_q, cmd_en_q, tmr_en_q, count_q[1:0]};

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tmr_en_d  = tmr_en_q;
        cmd_en_d  = cmd_en_q;
        rd_data_d = rd_data_q;
        if (push) begin
            fifo_d[wr_ptr_q] = main_cmd_data;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + 3'(push) - 3'(pop);
        if (rd0_rise) begin
            rd_data_d = head;
        end
        if (wr1_rise) begin
            tmr_en_d = scpu_dout[0];
            cmd_en_d = scpu_dout[1];
        end
        if (!tmr_en_q || tmr_wrap) begin
            tmr_cnt_d = 24'd0;
        end else begin
            tmr_cnt_d = tmr_cnt_q + 24'd1;
        end
        // A wrap in the same cycle as a clear wins, so no timer tick is lost.
        tmr_flag_d = tmr_flag_q;
        if (wr2_rise || tmr_clr_ack) begin
            tmr_flag_d = 1'b0;
        end
        if (tmr_wrap) begin
            tmr_flag_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_tmr_d  = pend_tmr_q;
        tmr_clr_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_pend || tmr_flag_q) begin
                    state_d    = REQ;
                    pend_tmr_d = ~cmd_pend;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    state_d = ACK;
                end else if (pend_tmr_q ? ~tmr_flag_q : ~cmd_pend) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (!ack_cond) begin
                    state_d     = IDLE;
                    tmr_clr_ack = pend_tmr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pend_tmr_q <= 1'b0;
            fifo_q     <= '{default: 8'h00};
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            tmr_en_q   <= 1'b0;
            cmd_en_q   <= 1'b0;
            tmr_flag_q <= 1'b0;
            tmr_cnt_q  <= 24'd0;
            rd_data_q  <= 8'h00;
            rd0_q      <= 1'b0;
            wr1_q      <= 1'b0;
            wr2_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_tmr_q <= pend_tmr_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tmr_en_q   <= tmr_en_d;
            cmd_en_q   <= cmd_en_d;
            tmr_flag_q <= tmr_flag_d;
            tmr_cnt_q  <= tmr_cnt_d;
            rd_data_q  <= rd_data_d;
            rd0_q      <= rd0_cond;
            wr1_q      <= wr1_cond;
            wr2_q      <= wr2_cond;
            ack_q      <= ack_cond;
        end
    end

    // The vector must already be on the bus in the first acknowledge cycle, while still in REQ.
    assign ack_window = ((state_q == REQ) & ack_rise) | (state_q == ACK);

    always_comb begin
        scpu_io_sel = 1'b0;
        scpu_io_din = 8'h00;
        if (reset_n) begin
            if (ack_window) begin
                scpu_io_sel = 1'b1;
                scpu_io_din = pend_tmr_q ? TMR_VEC : CMD_VEC;
            end else if (rd0_cond) begin
                scpu_io_sel = 1'b1;
                scpu_io_din = rd0_rise ? head : rd_data_q;
            end else if (rd1_cond) begin
                scpu_io_sel = 1'b1;
                scpu_io_din = status;
            end
        end
    end

    assign scpu_int      = (state_q == REQ);
    assign main_cmd_full = full;

endmodule
